// File: rtl/layer_if.sv
// Control, configuration and memory-port bundle between a layer controller and layer_engine.
interface layer_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
);
   logic              start;
   logic [ADDR_W-1:0] n_in;
   logic [ADDR_W-1:0] n_out;
   logic              relu_en;
   logic [ADDR_W-1:0] in_base;
   logic [ADDR_W-1:0] w_base;
   logic [ADDR_W-1:0] out_base;
   logic [ADDR_W-1:0] neuro_rd_addr;
   logic [DATA_W-1:0] neuro_rd_data;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [DATA_W-1:0] w_rd_data;
   logic              neuro_wr_en;
   logic [ADDR_W-1:0] neuro_wr_addr;
   logic [DATA_W-1:0] neuro_wr_data;
   logic              busy;
   logic              done;

   modport master (
      output start, n_in, n_out, relu_en, in_base, w_base, out_base,
      output neuro_rd_data, w_rd_data,
      input  neuro_rd_addr, w_rd_addr, neuro_wr_en, neuro_wr_addr, neuro_wr_data,
      input  busy, done
   );

   modport slave (
      input  start, n_in, n_out, relu_en, in_base, w_base, out_base,
      input  neuro_rd_data, w_rd_data,
      output neuro_rd_addr, w_rd_addr, neuro_wr_en, neuro_wr_addr, neuro_wr_data,
      output busy, done
   );
endinterface

// File: rtl/layer_engine.sv
// Fully-connected layer sequencer: walks each output neuron, accumulates weight x input
// products from external synchronous memories, then writes back ReLU/saturated results.
module layer_engine #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned ACC_W     = 24,
   parameter int unsigned FRAC_BITS = 4
) (
   input logic    clk,
   input logic    reset,
   layer_if.slave bus
);
   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic [ADDR_W-1:0]       ONE     = ADDR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_WRITE,
      S_DONE
   } state_e;

   state_e state_q, state_d;

   logic [ADDR_W-1:0] n_in_q, n_in_d;
   logic [ADDR_W-1:0] n_out_q, n_out_d;
   logic [ADDR_W-1:0] in_base_q, in_base_d;
   logic              relu_q, relu_d;
   logic [ADDR_W-1:0] i_q, i_d;
   logic [ADDR_W-1:0] j_q, j_d;
   logic              vld_q, vld_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;

   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              wr_en_q, wr_en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic signed [PROD_W-1:0] prod_c;
   logic signed [ACC_W-1:0]  prod_ext_c;

   assign prod_c     = $signed(bus.neuro_rd_data) * $signed(bus.w_rd_data);
   assign prod_ext_c = ACC_W'(prod_c);

   // Requantise: floor shift out the fraction, optional ReLU, clamp to the data range.
   function automatic logic [DATA_W-1:0] post_op(input logic signed [ACC_W-1:0] acc,
                                                 input logic relu);
      logic signed [ACC_W-1:0] sh;
      sh = acc >>> FRAC_BITS;
      if (relu && sh[ACC_W-1]) sh = '0;
      if (sh > SAT_MAX)      sh = SAT_MAX;
      else if (sh < SAT_MIN) sh = SAT_MIN;
      return DATA_W'(sh);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      n_in_d    = n_in_q;
      n_out_d   = n_out_q;
      in_base_d = in_base_q;
      relu_d    = relu_q;
      i_d       = i_q;
      j_d       = j_q;
      rd_addr_d = rd_addr_q;
      w_addr_d  = w_addr_q;
      wr_addr_d = wr_addr_q;
      vld_d     = (state_q == S_RUN);
      acc_d     = vld_q ? (acc_q + prod_ext_c) : acc_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               n_in_d    = bus.n_in;
               n_out_d   = bus.n_out;
               in_base_d = bus.in_base;
               relu_d    = bus.relu_en;
               i_d       = '0;
               j_d       = '0;
               acc_d     = '0;
               rd_addr_d = bus.in_base;
               w_addr_d  = bus.w_base;
               wr_addr_d = bus.out_base;
               if (bus.n_out == '0)     state_d = S_DONE;
               else if (bus.n_in == '0) state_d = S_WRITE;
               else                     state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Weight pointer runs on across neurons, giving row-major order without a multiplier.
            rd_addr_d = rd_addr_q + ONE;
            w_addr_d  = w_addr_q + ONE;
            if (i_q == n_in_q - ONE) state_d = S_DRAIN;
            else                     i_d     = i_q + ONE;
         end
         S_DRAIN: state_d = S_WRITE;
         S_WRITE: begin
            acc_d     = '0;
            i_d       = '0;
            rd_addr_d = in_base_q;
            wr_addr_d = wr_addr_q + ONE;
            if (j_q == n_out_q - ONE) begin
               state_d = S_DONE;
            end else begin
               j_d     = j_q + ONE;
               state_d = (n_in_q == '0) ? S_WRITE : S_RUN;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d    = (state_d == S_RUN) || (state_d == S_DRAIN) || (state_d == S_WRITE);
      done_d    = (state_d == S_DONE);
      wr_en_d   = (state_d == S_WRITE);
      wr_data_d = wr_en_d ? post_op(acc_d, relu_d) : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         n_in_q    <= '0;
         n_out_q   <= '0;
         in_base_q <= '0;
         relu_q    <= 1'b0;
         i_q       <= '0;
         j_q       <= '0;
         vld_q     <= 1'b0;
         acc_q     <= '0;
         rd_addr_q <= '0;
         w_addr_q  <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         n_in_q    <= n_in_d;
         n_out_q   <= n_out_d;
         in_base_q <= in_base_d;
         relu_q    <= relu_d;
         i_q       <= i_d;
         j_q       <= j_d;
         vld_q     <= vld_d;
         acc_q     <= acc_d;
         rd_addr_q <= rd_addr_d;
         w_addr_q  <= w_addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_en_q   <= wr_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.neuro_rd_addr = rd_addr_q;
   assign bus.w_rd_addr     = w_addr_q;
   assign bus.neuro_wr_en   = wr_en_q;
   assign bus.neuro_wr_addr = wr_addr_q;
   assign bus.neuro_wr_data = wr_data_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
endmodule

// File: tb/tb_layer_engine.sv
// Directed testbench for layer_engine with behavioural synchronous neuron RAM and weight ROM.
module tb_layer_engine;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   layer_if #(.DATA_W(8), .ADDR_W(8)) bus ();

   layer_engine #(.DATA_W(8), .ADDR_W(8), .ACC_W(24), .FRAC_BITS(4)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   logic [7:0] nram [0:255];
   logic [7:0] wrom [0:255];
   logic       ld_en = 1'b0;
   logic [7:0] ld_addr = '0;
   logic [7:0] ld_data = '0;

   // Memories with 1-cycle read latency; the bench preloads neuron RAM through ld_*.
   always @(posedge clk) begin
      bus.neuro_rd_data <= nram[bus.neuro_rd_addr];
      bus.w_rd_data     <= wrom[bus.w_rd_addr];
      if (ld_en) nram[ld_addr] <= ld_data;
      else if (bus.neuro_wr_en) nram[bus.neuro_wr_addr] <= bus.neuro_wr_data;
   end

   int n_cmp = 0;
   int n_bad = 0;

   int         busy_cnt, wr_cnt, done_cyc;
   logic       done_seen;
   logic [7:0] waddr_log [0:63];
   logic [7:0] wr_addr_log [0:15];
   logic [7:0] wr_data_log [0:15];
   int         wr_cyc_log [0:15];

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk);
      #1 ld_en = 1'b0;
   endtask

   // Launch one layer and log busy/write/done activity until done or a 200-cycle bound.
   task automatic run_layer(input logic [7:0] ni, input logic [7:0] no, input logic relu,
                            input logic [7:0] ib, input logic [7:0] wb, input logic [7:0] ob,
                            input int mid_start);
      int cyc;
      @(negedge clk);
      bus.n_in = ni; bus.n_out = no; bus.relu_en = relu;
      bus.in_base = ib; bus.w_base = wb; bus.out_base = ob;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      busy_cnt = 0; wr_cnt = 0; done_cyc = -1; done_seen = 1'b0; cyc = 0;
      while (!done_seen && cyc < 200) begin
         cyc++;
         if (bus.busy) begin
            if (busy_cnt < 64) waddr_log[busy_cnt] = bus.w_rd_addr;
            busy_cnt++;
         end
         if (bus.neuro_wr_en && wr_cnt < 16) begin
            wr_addr_log[wr_cnt] = bus.neuro_wr_addr;
            wr_data_log[wr_cnt] = bus.neuro_wr_data;
            wr_cyc_log[wr_cnt]  = cyc;
            wr_cnt++;
         end
         if (bus.done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
         end
         bus.start = (cyc == mid_start);
         if (!done_seen) @(negedge clk);
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      n_cmp++; if ({bus.busy, bus.done, bus.neuro_wr_en} !== 3'b000) begin n_bad++;
         $display("FAIL reset_ctrl got %b want 000", {bus.busy, bus.done, bus.neuro_wr_en}); end
      n_cmp++; if ({bus.neuro_wr_addr, bus.neuro_wr_data, bus.neuro_rd_addr, bus.w_rd_addr} !== 32'h0) begin n_bad++;
         $display("FAIL reset_bus got %h want 0",
                  {bus.neuro_wr_addr, bus.neuro_wr_data, bus.neuro_rd_addr, bus.w_rd_addr}); end
      reset = 1'b0;
   endtask

   task automatic test_basic_mac;
      poke(8'h20, 8'd16); poke(8'h21, 8'd32);
      wrom[8'h80] = 8'd16; wrom[8'h81] = 8'd16;
      run_layer(8'd2, 8'd1, 1'b0, 8'h20, 8'h80, 8'h30, -1);
      n_cmp++; if (done_cyc !== 5) begin n_bad++; $display("FAIL basic_done_cyc got %0d want 5", done_cyc); end
      n_cmp++; if (busy_cnt !== 4) begin n_bad++; $display("FAIL basic_busy got %0d want 4", busy_cnt); end
      n_cmp++; if (wr_cnt !== 1) begin n_bad++; $display("FAIL basic_wr_cnt got %0d want 1", wr_cnt); end
      n_cmp++; if ({wr_addr_log[0], wr_data_log[0]} !== 16'h3030) begin n_bad++;
         $display("FAIL basic_write got %h want 3030", {wr_addr_log[0], wr_data_log[0]}); end
      @(negedge clk);
      n_cmp++; if ({bus.done, bus.busy} !== 2'b00) begin n_bad++;
         $display("FAIL basic_done_pulse got %b want 00", {bus.done, bus.busy}); end
      n_cmp++; if (nram[8'h30] !== 8'h30) begin n_bad++; $display("FAIL basic_ram got %h want 30", nram[8'h30]); end
   endtask

   task automatic test_back_to_back;
      wrom[8'h82] = 8'd32;
      poke(8'h30, 8'h00);
      run_layer(8'd2, 8'd1, 1'b0, 8'h20, 8'h80, 8'h30, -1);
      // Second layer starts in the cycle after done and consumes the first layer's output.
      run_layer(8'd1, 8'd1, 1'b0, 8'h30, 8'h82, 8'h31, -1);
      n_cmp++; if (done_cyc !== 4) begin n_bad++; $display("FAIL b2b_done_cyc got %0d want 4", done_cyc); end
      n_cmp++; if ({wr_cnt[3:0], wr_addr_log[0], wr_data_log[0]} !== 20'h1_31_60) begin n_bad++;
         $display("FAIL b2b_write got %h want 13160", {wr_cnt[3:0], wr_addr_log[0], wr_data_log[0]}); end
   endtask

   task automatic test_relu;
      poke(8'h20, 8'd16);
      wrom[8'h80] = 8'hE0;
      run_layer(8'd1, 8'd1, 1'b0, 8'h20, 8'h80, 8'h30, -1);
      n_cmp++; if (wr_data_log[0] !== 8'hE0) begin n_bad++; $display("FAIL relu_off got %h want e0", wr_data_log[0]); end
      n_cmp++; if (busy_cnt !== 3) begin n_bad++; $display("FAIL relu_busy got %0d want 3", busy_cnt); end
      run_layer(8'd1, 8'd1, 1'b1, 8'h20, 8'h80, 8'h30, -1);
      n_cmp++; if (wr_data_log[0] !== 8'h00) begin n_bad++; $display("FAIL relu_on got %h want 00", wr_data_log[0]); end
   endtask

   task automatic test_saturation;
      poke(8'h20, 8'd127); poke(8'h21, 8'd127);
      wrom[8'h80] = 8'd127; wrom[8'h81] = 8'd127;
      run_layer(8'd2, 8'd1, 1'b0, 8'h20, 8'h80, 8'h30, -1);
      n_cmp++; if (wr_data_log[0] !== 8'h7F) begin n_bad++; $display("FAIL sat_pos got %h want 7f", wr_data_log[0]); end
      wrom[8'h80] = 8'h80; wrom[8'h81] = 8'h80;
      run_layer(8'd2, 8'd1, 1'b0, 8'h20, 8'h80, 8'h30, -1);
      n_cmp++; if (wr_data_log[0] !== 8'h80) begin n_bad++; $display("FAIL sat_neg got %h want 80", wr_data_log[0]); end
   endtask

   task automatic test_wrap_multi;
      poke(8'h10, 8'd16); poke(8'h11, 8'd32); poke(8'h12, 8'hF0);
      wrom[8'hFE] = 8'd16; wrom[8'hFF] = 8'd16; wrom[8'h00] = 8'd32;
      wrom[8'h01] = 8'hF0; wrom[8'h02] = 8'd16; wrom[8'h03] = 8'd8;
      run_layer(8'd3, 8'd2, 1'b0, 8'h10, 8'hFE, 8'h40, 3);
      n_cmp++; if (busy_cnt !== 10) begin n_bad++; $display("FAIL wrap_busy got %0d want 10", busy_cnt); end
      n_cmp++; if (done_cyc !== 11) begin n_bad++; $display("FAIL wrap_done_cyc got %0d want 11", done_cyc); end
      n_cmp++; if ({waddr_log[0], waddr_log[1], waddr_log[2]} !== 24'hFEFF00) begin n_bad++;
         $display("FAIL wrap_waddr0 got %h want feff00", {waddr_log[0], waddr_log[1], waddr_log[2]}); end
      n_cmp++; if ({waddr_log[5], waddr_log[6], waddr_log[7]} !== 24'h010203) begin n_bad++;
         $display("FAIL wrap_waddr1 got %h want 010203", {waddr_log[5], waddr_log[6], waddr_log[7]}); end
      n_cmp++; if (wr_cnt !== 2) begin n_bad++; $display("FAIL wrap_wr_cnt got %0d want 2", wr_cnt); end
      n_cmp++; if ({wr_addr_log[0], wr_data_log[0], wr_addr_log[1], wr_data_log[1]} !== 32'h4010_4108) begin n_bad++;
         $display("FAIL wrap_writes got %h want 40104108",
                  {wr_addr_log[0], wr_data_log[0], wr_addr_log[1], wr_data_log[1]}); end
   endtask

   task automatic test_degenerate;
      run_layer(8'd3, 8'd0, 1'b0, 8'h10, 8'h00, 8'h60, -1);
      n_cmp++; if (done_cyc !== 1) begin n_bad++; $display("FAIL nout0_done_cyc got %0d want 1", done_cyc); end
      n_cmp++; if ({busy_cnt[3:0], wr_cnt[3:0]} !== 8'h00) begin n_bad++;
         $display("FAIL nout0_activity got busy %0d writes %0d want 0 0", busy_cnt, wr_cnt); end
      run_layer(8'd0, 8'd2, 1'b1, 8'h10, 8'h00, 8'h60, -1);
      n_cmp++; if ({busy_cnt[3:0], wr_cnt[3:0]} !== 8'h22) begin n_bad++;
         $display("FAIL nin0_counts got busy %0d writes %0d want 2 2", busy_cnt, wr_cnt); end
      n_cmp++; if ({wr_addr_log[0], wr_data_log[0], wr_addr_log[1], wr_data_log[1]} !== 32'h6000_6100) begin n_bad++;
         $display("FAIL nin0_writes got %h want 60006100",
                  {wr_addr_log[0], wr_data_log[0], wr_addr_log[1], wr_data_log[1]}); end
      n_cmp++; if (wr_cyc_log[1] !== wr_cyc_log[0] + 1) begin n_bad++;
         $display("FAIL nin0_consecutive got cycles %0d,%0d want adjacent", wr_cyc_log[0], wr_cyc_log[1]); end
   endtask

   task automatic test_reset_mid;
      poke(8'h20, 8'd16); poke(8'h21, 8'd32); poke(8'h50, 8'h55);
      wrom[8'h80] = 8'd16; wrom[8'h81] = 8'd16;
      @(negedge clk);
      bus.n_in = 8'd2; bus.n_out = 8'd1; bus.relu_en = 1'b0;
      bus.in_base = 8'h20; bus.w_base = 8'h80; bus.out_base = 8'h50;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_pre got %b want 1", bus.busy); end
      #2 reset = 1'b1;
      #1;
      n_cmp++; if ({bus.busy, bus.done, bus.neuro_wr_en, bus.neuro_wr_addr, bus.neuro_wr_data,
                    bus.neuro_rd_addr, bus.w_rd_addr} !== 35'h0) begin n_bad++;
         $display("FAIL mid_reset_outputs got %h want 0", {bus.busy, bus.done, bus.neuro_wr_en,
                  bus.neuro_wr_addr, bus.neuro_wr_data, bus.neuro_rd_addr, bus.w_rd_addr}); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if ({bus.busy, nram[8'h50]} !== 9'h055) begin n_bad++;
         $display("FAIL mid_no_write got busy %b ram %h want 0 55", bus.busy, nram[8'h50]); end
      run_layer(8'd2, 8'd1, 1'b0, 8'h20, 8'h80, 8'h50, -1);
      n_cmp++; if ({done_cyc[3:0], busy_cnt[3:0], wr_data_log[0]} !== 16'h5430) begin n_bad++;
         $display("FAIL mid_rerun got done %0d busy %0d data %h want 5 4 30", done_cyc, busy_cnt, wr_data_log[0]); end
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0; bus.n_in = '0; bus.n_out = '0; bus.relu_en = 1'b0;
      bus.in_base = '0; bus.w_base = '0; bus.out_base = '0;
      for (int k = 0; k < 256; k++) wrom[k] = 8'h00;
      test_reset();
      for (int k = 0; k < 256; k++) poke(8'(k), 8'h00);
      test_basic_mac();
      test_back_to_back();
      test_relu();
      test_saturation();
      test_wrap_multi();
      test_degenerate();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/layer_engine.md
# layer_engine

Parametrised fully-connected layer sequencer, successor of the single-neuron address-generator/MAC pairing in the neural accelerator. On a `start` pulse it walks every output neuron of one layer. For each neuron it accumulates `n_in` signed fixed-point weight×input products read from the weight ROM and neuron RAM. It then applies optional ReLU and saturation and writes the result back into neuron RAM. It owns the read/write addressing and the arithmetic; the memories stay outside.

## Interface
- `DATA_W`, 8: signed two's-complement width of weights, activations and outputs.
- `ADDR_W`, 8: address width of the neuron RAM and the weight ROM.
- `ACC_W`, 24: accumulator width; must be at least 2·DATA_W.
- `FRAC_BITS`, 4: fractional bits of the Q format shared by weights and activations.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  launches one layer; sampled only in IDLE.
- `n_in`  in  ADDR_W  inputs per neuron; latched at start.
- `n_out`  in  ADDR_W  neurons in the layer; latched at start.
- `relu_en`  in  1  enables ReLU; latched at start.
- `in_base`, `w_base`, `out_base`  in  ADDR_W each  base addresses; latched at start.
- `neuro_rd_addr`  out  ADDR_W  neuron RAM read address.
- `neuro_rd_data`  in  DATA_W  neuron RAM read data; synchronous read, 1-cycle latency.
- `w_rd_addr`  out  ADDR_W  weight ROM read address.
- `w_rd_data`  in  DATA_W  weight ROM read data; same 1-cycle latency.
- `neuro_wr_en`, `neuro_wr_addr`, `neuro_wr_data`  out  1/ADDR_W/DATA_W  neuron RAM write port.
- `busy`  out  1  high in RUN, DRAIN and WRITE.
- `done`  out  1  one-cycle pulse after the last write.

## Operation
- **Addressing (all mod 2^ADDR_W, wrap silently)**
  - Input i: `in_base + i`.
  - Weight (j, i): `w_base + j·n_in + i`, row-major. Produced by a running pointer that continues across neurons; no multiplier.
  - Output j: `out_base + j`.
- **FSM states:** IDLE, RUN, DRAIN, WRITE, DONE.
- **IDLE**
  - `start`=1 latches the configuration, clears the accumulator and sets i=j=0.
  - Next state: DONE if `n_out`=0, else WRITE if `n_in`=0, else RUN.
- **RUN**
  - Drives the addresses for input i; i increments each cycle.
  - A product is accumulated on the edge after its data returns, tracked by a one-bit valid pipeline.
  - After issuing i=`n_in`−1, goes to DRAIN.
- **DRAIN:** accumulates the last product, then goes to WRITE.
- **WRITE**
  - `neuro_wr_en`=1 for exactly one cycle, with `neuro_wr_addr`=`out_base+j` and `neuro_wr_data`=f(acc).
  - Then clears the accumulator and sets i=0.
  - If j=`n_out`−1, goes to DONE; else j increments and the next state is RUN (or WRITE again if `n_in`=0).
- **DONE:** `done`=1 for one cycle, `busy`=0, then IDLE.
- **`start` outside IDLE** (including DONE) is ignored.
- **Arithmetic**
  - Product is signed 2·DATA_W, sign-extended to ACC_W; accumulation wraps at ACC_W.
  - f(acc): arithmetic shift right by FRAC_BITS (floor), then ReLU if enabled (negative→0), then saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- **Reset mid-operation:** immediate return to IDLE. The in-progress neuron is abandoned; no partial write.

## Timing
- **Reset values:** all outputs 0, state IDLE, accumulator 0.
- **Start:** `start` sampled at edge E0; `busy` rises in the cycle after E0.
- **Per neuron:** `n_in`+2 cycles (n_in RUN, 1 DRAIN, 1 WRITE); 1 cycle if `n_in`=0.
- **Per layer:** `busy` lasts `n_out`·(`n_in`+2) cycles, followed by exactly one `done` cycle.
  - `n_out`=0: `done` in the cycle after E0, with no writes and `busy` never high.
- **Write port:** `neuro_wr_*` are valid only while `neuro_wr_en`=1. Read addresses are don't-care outside RUN.
- **Back-to-back layers:** a `start` in the cycle after DONE (i.e. back in IDLE) is accepted. The next layer may read the previous layer's output region.

## Test plan
Values below use DATA_W=8, FRAC_BITS=4 (16 = 1.0).
- **Basic MAC:** `n_in`=2, `n_out`=1, inputs 16,32, weights 16,16 → one write of 48 (0x30) at `out_base`; `busy` high 4 cycles, `done` in the 5th.
- **ReLU:** input 16, weight −32, `n_in`=1 → writes 0xE0 with `relu_en`=0, 0x00 with `relu_en`=1.
- **Saturation:** inputs 127,127 × weights 127,127 → 0x7F; with weights −128,−128 → 0x80.
- **Wrap and multi-neuron:** `n_in`=3, `n_out`=2, `w_base`=0xFE → weight addresses FE,FF,00 then 01,02,03; writes at `out_base`, `out_base`+1; `busy` 10 cycles; `start` pulsed mid-run is ignored.
- **Degenerate sizes:** `n_out`=0 → `done` the next cycle, no `neuro_wr_en`. `n_in`=0, `n_out`=2 → two consecutive single-cycle writes of 0x00.
- **Reset mid-operation:** `reset` asserted during RUN of neuron 0 → all outputs 0 without waiting for a clock edge and no write. After release, a fresh `start` completes the basic-MAC case correctly.
